// File: rtl/alu_unit.sv
// 32-bit execute-stage ALU: combinational result/zero plus an enable-gated output register.
// Define ALU_FLAGS_EN to add carry/overflow/negative flags and their registered copies.
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alucontrol,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q
`ifdef ALU_FLAGS_EN
    ,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             carry_q,
    output logic             overflow_q,
    output logic             negative_q
`endif
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt_bit;

`ifdef ALU_FLAGS_EN
    logic add_cout;
    logic sub_cout;

    // Subtract as a + ~b + 1 so the carry-out is the no-borrow flag.
    assign {add_cout, sum}  = {1'b0, a} + {1'b0, b};
    assign {sub_cout, diff} = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
`else
    assign sum  = a + b;
    assign diff = a - b;
`endif

    // True signed compare; sign of (a-b) alone is wrong when the subtraction overflows.
    assign slt_bit = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        case (alucontrol)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt_bit};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

`ifdef ALU_FLAGS_EN
    always_comb begin
        carry    = 1'b0;
        overflow = 1'b0;
        case (alucontrol)
            OP_ADD: begin
                carry    = add_cout;
                overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                carry    = sub_cout;
                overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            default: begin
                carry    = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

    assign negative = result[MSB];
`endif

    logic [WIDTH-1:0] result_d;
    logic             zero_d;

    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        if (en) begin
            result_d = result;
            zero_d   = zero;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic carry_d;
    logic overflow_d;
    logic negative_d;

    always_comb begin
        carry_d    = carry_q;
        overflow_d = overflow_q;
        negative_d = negative_q;
        if (en) begin
            carry_d    = carry;
            overflow_d = overflow;
            negative_d = negative;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            negative_q <= negative_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed spec vectors, reset/enable checks, randomized ops vs arithmetic model.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alucontrol;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;
`ifdef ALU_FLAGS_EN
    logic carry, overflow, negative, carry_q, overflow_q, negative_q;
`endif

    alu_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .a          (a),
        .b          (b),
        .alucontrol (alucontrol),
        .result     (result),
        .zero       (zero),
        .result_q   (result_q),
        .zero_q     (zero_q)
`ifdef ALU_FLAGS_EN
        ,
        .carry      (carry),
        .overflow   (overflow),
        .negative   (negative),
        .carry_q    (carry_q),
        .overflow_q (overflow_q),
        .negative_q (negative_q)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        n;
    } model_t;

    int tests = 0;
    int fails = 0;
    model_t q_m;

    // Reference computed with 64-bit arithmetic on the integer values of the operands.
    function automatic model_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        model_t m;
        longint ux, uy, sx, sy, full;
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        m.res = 32'h0;
        m.c = 1'b0;
        m.v = 1'b0;
        case (op)
            3'd0: m.res = x & y;
            3'd1: m.res = x | y;
            3'd2: begin
                full = ux + uy;
                m.res = full[31:0];
                m.c = (full >= 64'sh1_0000_0000);
                m.v = ((sx + sy) > 64'sd2147483647) || ((sx + sy) < -64'sd2147483648);
            end
            3'd6: begin
                full = ux - uy;
                m.res = full[31:0];
                m.c = (ux >= uy);
                m.v = ((sx - sy) > 64'sd2147483647) || ((sx - sy) < -64'sd2147483648);
            end
            3'd7: m.res = (sx < sy) ? 32'd1 : 32'd0;
            default: m.res = 32'h0;
        endcase
        m.z = (m.res == 32'h0);
        m.n = m.res[31];
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag);
        model_t m;
        m = model(a, b, alucontrol);
        chk({tag, ".result"}, result, m.res);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, m.z});
`ifdef ALU_FLAGS_EN
        chk({tag, ".carry"}, {31'b0, carry}, {31'b0, m.c});
        chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, m.v});
        chk({tag, ".negative"}, {31'b0, negative}, {31'b0, m.n});
`endif
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".result_q"}, result_q, q_m.res);
        chk({tag, ".zero_q"}, {31'b0, zero_q}, {31'b0, q_m.z});
`ifdef ALU_FLAGS_EN
        chk({tag, ".carry_q"}, {31'b0, carry_q}, {31'b0, q_m.c});
        chk({tag, ".overflow_q"}, {31'b0, overflow_q}, {31'b0, q_m.v});
        chk({tag, ".negative_q"}, {31'b0, negative_q}, {31'b0, q_m.n});
`endif
    endtask

    task automatic reset_model();
        q_m.res = 32'h0;
        q_m.z = 1'b1;
        q_m.c = 1'b0;
        q_m.v = 1'b0;
        q_m.n = 1'b0;
    endtask

    // Drive at the falling edge, then check the combinational outputs 1 time unit later.
    task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op,
                         input logic e, input string tag);
        @(negedge clk);
        a = x;
        b = y;
        alucontrol = op;
        en = e;
        #1;
        chk_comb(tag);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (en && !reset) q_m = model(a, b, alucontrol);
        #1;
        chk_regs(tag);
    endtask

    initial begin
        logic [31:0] corners [5];
        logic [31:0] ra, rb;
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;

        reset = 1'b1;
        en = 1'b0;
        a = 32'h0;
        b = 32'h0;
        alucontrol = 3'b000;
        reset_model();
        #12;
        chk_regs("reset");

        @(negedge clk);
        reset = 1'b0;

        apply(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b000, 1'b1, "and");
        chk("and.lit", result, 32'h0000_0000);
        chk("and.zlit", {31'b0, zero}, 32'd1);
        tick("and.reg");

        apply(32'h12345678, 32'h87654321, 3'b001, 1'b1, "or");
        chk("or.lit", result, 32'h9775_5779);
        tick("or.reg");

        apply(32'd100, 32'd23, 3'b010, 1'b1, "add");
        chk("add.lit", result, 32'd123);
        tick("add.reg");

        apply(32'd50, 32'd75, 3'b110, 1'b1, "sub");
        chk("sub.lit", result, 32'hFFFF_FFE7);
`ifdef ALU_FLAGS_EN
        chk("sub.carry_lit", {31'b0, carry}, 32'd0);
        chk("sub.neg_lit", {31'b0, negative}, 32'd1);
`endif
        tick("sub.reg");

        apply(32'd5, 32'd10, 3'b111, 1'b1, "slt_a");
        chk("slt_a.lit", result, 32'd1);
        apply(32'd20, 32'd10, 3'b111, 1'b1, "slt_b");
        chk("slt_b.lit", result, 32'd0);
        apply(32'h80000000, 32'h00000001, 3'b111, 1'b1, "slt_c");
        chk("slt_c.lit", result, 32'd1);
        apply(32'h7FFFFFFF, 32'h80000000, 3'b111, 1'b1, "slt_d");
        chk("slt_d.lit", result, 32'd0);
        tick("slt.reg");

        apply(32'hFFFFFFFF, 32'h0, 3'b011, 1'b1, "undef3");
        chk("undef3.lit", result, 32'h0);
        chk("undef3.zlit", {31'b0, zero}, 32'd1);
        apply(32'hFFFFFFFF, 32'h0, 3'b100, 1'b1, "undef4");
        chk("undef4.lit", result, 32'h0);
        apply(32'hFFFFFFFF, 32'h0, 3'b101, 1'b1, "undef5");
        chk("undef5.lit", result, 32'h0);
        tick("undef.reg");

        // Load a non-zero value, then show en=0 holds it across edges.
        apply(32'h8000_0000, 32'h8000_0000, 3'b010, 1'b1, "ovf_add");
        tick("ovf_add.reg");
        apply(32'h8000_0000, 32'h1, 3'b001, 1'b1, "load");
        tick("load.reg");
        chk("load.lit", result_q, 32'h8000_0001);
        apply(32'h0, 32'h0, 3'b000, 1'b0, "hold");
        tick("hold.reg1");
        tick("hold.reg2");
        chk("hold.lit", result_q, 32'h8000_0001);

        // Asynchronous reset between clock edges; combinational path unaffected.
        apply(32'h1234, 32'h1, 3'b010, 1'b1, "pre_rst");
        #1;
        reset = 1'b1;
        reset_model();
        #1;
        chk_regs("async_rst");
        chk_comb("rst_comb");
        tick("rst_hold_edge");
        @(negedge clk);
        reset = 1'b0;
        tick("post_rst_load");
        chk("post_rst.lit", result_q, 32'h1235);

        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(3) == 0) ? corners[$urandom_range(4)] : $urandom;
            rb = ($urandom_range(3) == 0) ? corners[$urandom_range(4)] : $urandom;
            apply(ra, rb, 3'($urandom_range(7)), 1'($urandom_range(3) != 0), "rnd");
            tick("rnd.reg");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
